muldiv_sequencer: RTL and testbench

- Multi-cycle execution controller for the M-extension instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) of the RV32IM core.
- Sits beside the ALU in the execute stage. The decoder raises start for OP opcode 0110011 with funct7=0000001.
- Holds the pipeline via stall while it works, then returns one registered result with a single-cycle done pulse.
- Division is a radix-2 restoring iteration, with RISC-V divide-by-zero and overflow cases resolved up front.

---
 rtl/muldiv_sequencer.sv | 169 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle execution controller for the RV32M instructions
//               (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). Holds the pipeline
//               with stall, then returns one registered result together with
//               a single-cycle done pulse. Division is radix-2 restoring.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t           state, next_state;
  logic             accept;

  // Latched operation and datapath registers
  logic [1:0]       op;
  logic [XLEN-1:0]  mul_a, mul_b;
  logic [XLEN-1:0]  quot, rem, divisor;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;

  // Accept-time decode of the incoming request
  logic             signed_div, div_by_zero, div_ovf, div_special;
  logic [XLEN-1:0]  special_result, rs1_mag, rs2_mag;

  assign signed_div     = ~funct3[0];
  assign div_by_zero    = (rs2_val == '0);
  assign div_ovf        = signed_div & (rs1_val == MIN_INT) & (rs2_val == ALL_ONES);
  assign div_special    = div_by_zero | div_ovf;
  assign special_result = div_by_zero ? (funct3[1] ? rs1_val : ALL_ONES)
                                      : (funct3[1] ? '0      : MIN_INT);
  assign rs1_mag        = (signed_div & rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
  assign rs2_mag        = (signed_div & rs2_val[XLEN-1]) ? -rs2_val : rs2_val;

  // Multiply: the low 2*XLEN bits of the product of sign/zero-extended operands
  // are identical to the low bits of the full 2*XLEN+2-bit product.
  logic              a_signed, b_signed;
  logic [2*XLEN-1:0] a_wide, b_wide, product;
  logic [XLEN-1:0]   mul_result;

  assign a_signed   = op[0] ^ op[1];          // MULH, MULHSU
  assign b_signed   = (op == 2'b01);          // MULH only
  assign a_wide     = {{XLEN{a_signed & mul_a[XLEN-1]}}, mul_a};
  assign b_wide     = {{XLEN{b_signed & mul_b[XLEN-1]}}, mul_b};
  assign product    = a_wide * b_wide;
  assign mul_result = (op == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Restoring divide step: the XLEN+1-bit compare is the widened trial subtract
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] trial, rem_next, quot_next, q_fixed, r_fixed;

  assign shifted   = {rem, quot[XLEN-1]};
  assign fits      = (shifted >= {1'b0, divisor});
  assign trial     = shifted[XLEN-1:0] - divisor;
  assign rem_next  = fits ? trial : shifted[XLEN-1:0];
  assign quot_next = {quot[XLEN-2:0], fits};
  assign q_fixed   = q_neg ? -quot : quot;
  assign r_fixed   = r_neg ? -rem  : rem;

  // Next-state, accept and combinational stall
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    stall      = 1'b0;
    if (flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            accept = 1'b1;
            stall  = 1'b1;
            if (!funct3[2])      next_state = ST_MUL;
            else if (div_special) next_state = ST_DONE;
            else                  next_state = ST_DIV;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_MUL:  next_state = ST_DONE;
        ST_DIV:  next_state = (cnt == LAST_IT) ? ST_FIX : ST_DIV;
        ST_FIX:  next_state = ST_DONE;
        default: next_state = ST_IDLE;
      endcase
    end
    if (state == ST_MUL || state == ST_DIV || state == ST_FIX) stall = 1'b1;
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ST_MUL) || (next_state == ST_DIV) || (next_state == ST_FIX);
      done  <= (next_state == ST_DONE);
    end
  end

  // Operand latch, divide iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      quot    <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      result  <= '0;
    end else if (accept) begin
      op      <= funct3[1:0];
      mul_a   <= rs1_val;
      mul_b   <= rs2_val;
      quot    <= rs1_mag;
      rem     <= '0;
      divisor <= rs2_mag;
      cnt     <= '0;
      q_neg   <= signed_div & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
      r_neg   <= signed_div & rs1_val[XLEN-1];
      if (funct3[2] && div_special) result <= special_result;
    end else if (!flush) begin
      case (state)
        ST_MUL: result <= mul_result;
        ST_DIV: begin
          rem  <= rem_next;
          quot <= quot_next;
          cnt  <= cnt + CNT_W'(1);
        end
        ST_FIX: result <= op[1] ? r_fixed : q_fixed;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer: directed cases,
//               flush/reset aborts, back-to-back issue and random operations
//               compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        stall, busy, done;
  logic [31:0] result;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  // Reference result computed from the RISC-V M-extension arithmetic rules
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    int         q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = int'(a) / int'(b); return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = int'(a) % int'(b); return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges from the accepting edge until done is visible
  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for done with a bound, check latency/result/pulse
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int lat, exp_lat;
    exp_lat = ref_latency(f, a, b);
    funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
    #1;
    chk({tag, ".stall_acc"}, 32'(stall), 32'd1);
    tick();
    start = 1'b0; lat = 1;
    funct3 = 3'($urandom); rs1_val = $urandom; rs2_val = $urandom;
    #1;
    if (exp_lat > 1) begin
      chk({tag, ".busy_work"}, 32'(busy), 32'd1);
      chk({tag, ".stall_work"}, 32'(stall), 32'd1);
    end
    while (done !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic        seen;
    logic [2:0]  f;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = '0; rs1_val = '0; rs2_val = '0;
    repeat (3) tick();
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.result", result, 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();

    // Multiply family
    run_op("mul", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // Normal division
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);

    // Special cases resolved at accept
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush at iteration 10 of a divide
    funct3 = 3'd4; rs1_val = 32'hFFFF_FF9C; rs2_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    #1;
    chk("flush.stall_before", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush.busy", 32'(busy), 32'd0);
    chk("flush.stall", 32'(stall), 32'd0);
    chk("flush.done", 32'(done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("flush.no_done", 32'(seen), 32'd0);
    run_op("flush_mul", 3'd0, 32'd6, 32'd7, 32'd42);

    // Reset in the middle of a divide
    funct3 = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.result", result, 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    run_op("midrst_mul", 3'd0, 32'd11, 32'd13, 32'd143);

    // Back-to-back with a start ignored mid-divide
    funct3 = 3'd5; rs1_val = 32'd9; rs2_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; lat = 1;
    repeat (5) begin tick(); lat++; end
    funct3 = 3'd0; rs1_val = 32'd5; rs2_val = 32'd5; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    while (done !== 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    chk("b2b.div_latency", 32'(lat), 32'd34);
    chk("b2b.div_result", result, 32'd3);
    funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd3; start = 1'b1;
    #1;
    chk("b2b.stall_restart", 32'(stall), 32'd1);
    tick();
    start = 1'b0;
    chk("b2b.gap", 32'(done), 32'd0);
    tick();
    chk("b2b.mul_done", 32'(done), 32'd1);
    chk("b2b.mul_result", result, 32'd9);
    tick();
    chk("b2b.mul_pulse", 32'(done), 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_result(f, a, b));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
